// File: rtl/neighbor_search_sched.sv
// Sequences open-list lookups for each in-grid neighbour of the current A* node.
// Define NEIGHBOR_SEARCH_DIAG_EN for 8-connectivity (idx 4..7 = NE, SE, SW, NW).
module neighbor_search_sched #(
  parameter int GRID_W  = 20,
  parameter int GRID_H  = 20,
  parameter int COORD_W = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [7:0]         nbr_valid,
  output logic [7:0]         nbr_found,
  output logic               srch_req,
  output logic [COORD_W-1:0] srch_x,
  output logic [COORD_W-1:0] srch_y,
  input  logic               srch_ack,
  input  logic               srch_found
);

`ifdef NEIGHBOR_SEARCH_DIAG_EN
  localparam logic [2:0] LAST      = 3'd7;
  localparam logic [7:0] LIVE_MASK = 8'hFF;
`else
  localparam logic [2:0] LAST      = 3'd3;
  localparam logic [7:0] LIVE_MASK = 8'h0F;
`endif

  localparam int SW    = COORD_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic signed [SW-1:0] Z0 = '0;
  localparam logic signed [SW-1:0] P1 = SW'(1);
  localparam logic signed [SW-1:0] M1 = -P1;
  localparam logic signed [SW-1:0] GW = SW'(GRID_W);
  localparam logic signed [SW-1:0] GH = SW'(GRID_H);
  localparam logic [CNT_W-1:0]     TO = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t               state;
  logic [COORD_W-1:0]   base_x, base_y;
  logic [2:0]           idx;
  logic [CNT_W-1:0]     wait_cnt;
  logic [CNT_W-1:0]     wait_cnt_nxt;
  logic [7:0]           valid_r, found_r;
  logic signed [SW-1:0] nx, ny;
  logic                 nbr_in;

  function automatic logic signed [SW-1:0] step_x(input logic [2:0] i);
    case (i)
      3'd1, 3'd4, 3'd5: return P1;
      3'd3, 3'd6, 3'd7: return M1;
      default:          return Z0;
    endcase
  endfunction

  function automatic logic signed [SW-1:0] step_y(input logic [2:0] i);
    case (i)
      3'd0, 3'd4, 3'd7: return M1;
      3'd2, 3'd5, 3'd6: return P1;
      default:          return Z0;
    endcase
  endfunction

  // Signed, one bit wider than a coordinate, so x=0 minus 1 is negative rather than wrapping.
  function automatic logic in_grid(input logic signed [SW-1:0] px,
                                   input logic signed [SW-1:0] py);
    return (px >= Z0) && (px < GW) && (py >= Z0) && (py < GH);
  endfunction

  always_comb begin
    nx           = $signed({1'b0, base_x}) + step_x(idx);
    ny           = $signed({1'b0, base_y}) + step_y(idx);
    nbr_in       = in_grid(nx, ny);
    wait_cnt_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      error    <= 1'b0;
      srch_req <= 1'b0;
      srch_x   <= '0;
      srch_y   <= '0;
      valid_r  <= '0;
      found_r  <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      base_x   <= '0;
      base_y   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_x  <= cur_x;
            base_y  <= cur_y;
            valid_r <= '0;
            found_r <= '0;
            error   <= 1'b0;
            idx     <= '0;
            state   <= S_GEN;
          end
        end
        S_GEN: begin
          if (nbr_in) begin
            valid_r[idx] <= 1'b1;
            srch_x       <= nx[COORD_W-1:0];
            srch_y       <= ny[COORD_W-1:0];
            wait_cnt     <= '0;
            srch_req     <= 1'b1;
            state        <= S_WAIT;
          end else begin
            valid_r[idx] <= 1'b0;
            state        <= S_NEXT;
          end
        end
        S_WAIT: begin
          // An ack arriving on the final allowed cycle still counts as a response.
          if (srch_ack) begin
            found_r[idx] <= srch_found;
            srch_req     <= 1'b0;
            state        <= S_NEXT;
          end else if (wait_cnt_nxt == TO) begin
            wait_cnt <= wait_cnt_nxt;
            error    <= 1'b1;
            srch_req <= 1'b0;
            state    <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt_nxt;
          end
        end
        S_NEXT: begin
          if (idx == LAST) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 3'd1;
            state <= S_GEN;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign nbr_valid = valid_r & LIVE_MASK;
  assign nbr_found = found_r & LIVE_MASK;

endmodule

// File: doc/neighbor_search_sched.md
Name: neighbor_search_sched

Overview:
- Controller that sequences open-list membership lookups for every grid neighbour of the current A* node.
- Sits between the expansion logic and the linear open-list searcher. On `start` it generates neighbour coordinates and discards out-of-grid ones.
- Issues one lookup per in-bounds neighbour over a req/ack handshake and collects the results into per-neighbour masks for the cost-update stage.

Parameters:
- GRID_W, 20, grid width in cells; valid x range is 0..GRID_W-1.
- GRID_H, 20, grid height in cells; valid y range is 0..GRID_H-1.
- COORD_W, 8, coordinate width in bits.
- TIMEOUT, 1023, maximum number of WAIT cycles without `srch_ack` before abort.

Ports:
- Clk  input  1  clock.
- Reset_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin a scan; sampled only in IDLE.
- cur_x  input  COORD_W  current node x; latched on accepted start.
- cur_y  input  COORD_W  current node y; latched on accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the scan completes or aborts.
- error  output  1  timeout flag; held until the next accepted start.
- nbr_valid  output  8  bit i = neighbour i is in bounds.
- nbr_found  output  8  bit i = neighbour i is present in the open list.
- srch_req  output  1  lookup request to the searcher.
- srch_x  output  COORD_W  lookup x coordinate.
- srch_y  output  COORD_W  lookup y coordinate.
- srch_ack  input  1  searcher finished; one-cycle pulse.
- srch_found  input  1  searcher result; valid only with `srch_ack`.

Behaviour:
- Reset (`Reset_n`=0, immediate): state=IDLE; busy, done, error, srch_req=0; nbr_valid, nbr_found, srch_x, srch_y=0; idx=0; timeout counter=0. Reset mid-scan drops `srch_req` at once, and no done pulse follows.
- Neighbour order, idx 0..3: N(x,y-1), E(x+1,y), S(x,y+1), W(x-1,y). With the optional feature, idx 4..7: NE, SE, SW, NW.
- Neighbour arithmetic: one bit wider than COORD_W, signed. A neighbour is in bounds iff 0<=nx<GRID_W and 0<=ny<GRID_H; x=0 minus 1 is out of bounds, not a wrap.
- IDLE:
  - busy=0.
  - start=1: latch cur_x/cur_y; clear nbr_valid, nbr_found and error; idx=0; go GEN.
  - srch_ack in IDLE is ignored.
- GEN (1 cycle):
  - Out of bounds: nbr_valid[idx]=0; go NEXT.
  - In bounds: nbr_valid[idx]=1; register srch_x/srch_y; clear the timeout counter; go WAIT.
- WAIT:
  - srch_req=1; srch_x/srch_y held stable.
  - srch_ack=1: nbr_found[idx]=srch_found; go NEXT; srch_req is low from the following cycle.
  - Otherwise the counter increments. When it reaches TIMEOUT with no ack: error=1; go DONE; remaining bits stay 0.
- NEXT (1 cycle): if idx==LAST (3, or 7 with the optional feature) go DONE; else idx+1, go GEN.
- DONE: done=1 for exactly one cycle; go IDLE. Masks and error hold until the next accepted start.
- Latency: from the start-accept edge to done high = 1 + Σ over neighbours of (2 if out of bounds, else 2+L_i), where L_i = WAIT cycles including the ack cycle (minimum 1).
- Boundary cases:
  - start while busy is ignored.
  - start asserted in the same cycle as DONE is ignored; it is accepted the next cycle if still high.
  - srch_ack outside WAIT is ignored.
  - srch_found without srch_ack is ignored.
  - Each scan issues at most one request per neighbour.
- Bits above LAST in nbr_valid and nbr_found are always 0.

Optional Feature:
- Macro: NEIGHBOR_SEARCH_DIAG_EN.
- Defined: 8-connectivity; idx 0..7 are scanned and all 8 mask bits are live.
- Undefined: 4-connectivity; idx 0..3 only; nbr_valid[7:4] and nbr_found[7:4] are tied to 0; the port list is unchanged.

Test Plan:
- Interior node, 4-conn, no macro. Reset, start with cur=(5,5); searcher acks after 1 cycle, found for E only.
  - Requests go out in order (5,4),(6,5),(5,6),(4,5).
  - Result: nbr_valid=8'h0F, nbr_found=8'h02, error=0.
  - done pulses 1+4*3=13 cycles after the start edge.
- Corner node (0,0), no macro.
  - Exactly 2 requests: (1,0) then (0,1).
  - Result: nbr_valid=8'h06; done 1+2+3+3+2=11 cycles after start.
- Far corner (19,19), macro defined.
  - Requests go to N, W and NW only.
  - Result: nbr_valid=8'h89; nbr_found matches searcher responses; bits above 7 are irrelevant.
- Timeout: start at (5,5) and never ack.
  - srch_req stays high with coordinates (5,4) for 1023 cycles.
  - Then error=1, a single done pulse, nbr_valid=8'h01, srch_req drops.
- Protocol: pulse start during WAIT; pulse srch_ack while in IDLE.
  - Neither affects state, masks or request count.
  - The next real scan completes normally.
- Reset mid-scan: deassert Reset_n during WAIT of idx 2.
  - srch_req drops in the same cycle; all outputs are 0; no done pulse.
  - A subsequent start at (3,3) produces a clean result.
